hex_input: RTL

- Input-side counterpart of the PDU 7-segment display driver.
- Turns 16 raw slide switches plus three push buttons (delete, clear, enter) into a 32-bit hex value entered digit by digit.
- Feeds the live value back to the display path and hands the finished value to the PDU over a valid/ready handshake.
- Runs on the 100 MHz board clock.

---
 rtl/pdu_pkg.sv | 40 ++++
 rtl/hex_input_if.sv | 12 +
 rtl/input_debouncer.sv | 51 +++++
 rtl/hex_input.sv | 108 ++++++++++
 4 files changed

// File: rtl/pdu_pkg.sv
// Shared PDU types and constants for the front-panel input/display path.
package pdu_pkg;

  localparam int unsigned SAMPLE_CYCLES_100MHZ = 1000000;
  localparam int unsigned HEX_DIGITS           = 8;
  localparam int unsigned DATA_W               = 32;
  localparam int unsigned SW_W                 = 16;
  localparam int unsigned DCNT_W               = 4;

  typedef logic [3:0] digit_t;

  // Raw front-panel inputs as one debounced bundle.
  typedef struct packed {
    logic            btn_enter;
    logic            btn_clr;
    logic            btn_del;
    logic [SW_W-1:0] sw;
  } raw_in_t;

  localparam int unsigned RAW_W = $bits(raw_in_t);

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CLR,
    ACT_ENTER,
    ACT_DEL,
    ACT_SW
  } action_e;

  // Index of the lowest set bit; simultaneous toggles resolve to this digit.
  function automatic digit_t lowest_set(input logic [SW_W-1:0] v);
    digit_t d;
    d = '0;
    for (int i = SW_W - 1; i >= 0; i--) begin
      if (v[i]) d = digit_t'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/hex_input_if.sv
// Submitted-value handshake between hex_input and the PDU.
interface hex_input_if;
  import pdu_pkg::*;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/input_debouncer.sv
// Two-FF synchronizer plus tick-sampled two-sample-agreement debouncer.
module input_debouncer #(
  parameter int unsigned W             = 19,
  parameter int unsigned SAMPLE_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] stable,
  output logic         primed
);

  logic [W-1:0]     sync1;
  logic [W-1:0]     sync2;
  logic [W-1:0]     sample;
  logic [W-1:0]     agree_c;
  logic [CNT_W-1:0] cnt;
  logic             tick_c;
  logic             seen_tick;

  // Tick on the last count of each sample period; bits agreeing across two ticks may move.
  always_comb begin
    tick_c  = (cnt == CNT_W'(SAMPLE_CYCLES - 1));
    agree_c = ~(sync2 ^ sample);
  end

  // Synchronize, count the sample period, sample and update stable state on tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      sample    <= '0;
      stable    <= '0;
      cnt       <= '0;
      seen_tick <= 1'b0;
      primed    <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      cnt   <= tick_c ? '0 : cnt + CNT_W'(1);
      if (tick_c) begin
        sample    <= sync2;
        stable    <= (agree_c & sync2) | (~agree_c & stable);
        seen_tick <= 1'b1;
        if (seen_tick) primed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_input.sv
// Switch/button hex entry: debounced edges drive a digit shift register and a submit handshake.
module hex_input
  import pdu_pkg::*;
#(
  parameter int unsigned SAMPLE_CYCLES = SAMPLE_CYCLES_100MHZ,
  parameter int unsigned CNT_W         = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW_W-1:0]   sw,
  input  logic              btn_del,
  input  logic              btn_clr,
  input  logic              btn_enter,
  output logic [DATA_W-1:0] cur_data,
  output logic [DCNT_W-1:0] digit_cnt,
  hex_input_if.master       out_if
);

  raw_in_t          raw_c;
  raw_in_t          stable_c;
  raw_in_t          prev_q;
  logic [RAW_W-1:0] raw_bits_c;
  logic [RAW_W-1:0] stable_bits;
  logic             primed;
  logic             primed_q;
  logic [SW_W-1:0]  sw_diff_c;
  logic             sw_evt_c;
  logic             del_evt_c;
  logic             clr_evt_c;
  logic             enter_evt_c;
  action_e          act_c;

  // Bundle raw inputs for the debouncer and unpack its stable view.
  always_comb begin
    raw_c           = '0;
    raw_c.sw        = sw;
    raw_c.btn_del   = btn_del;
    raw_c.btn_clr   = btn_clr;
    raw_c.btn_enter = btn_enter;
    raw_bits_c      = raw_c;
    stable_c        = raw_in_t'(stable_bits);
  end

  input_debouncer #(
    .W             (RAW_W),
    .SAMPLE_CYCLES (SAMPLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_debouncer (
    .clk    (clk),
    .rst    (rst),
    .din    (raw_bits_c),
    .stable (stable_bits),
    .primed (primed)
  );

  // One-cycle events from stable-state changes, resolved to a single action by priority.
  // Events wait one extra cycle after priming so the priming load itself is silent.
  always_comb begin
    sw_diff_c   = stable_c.sw ^ prev_q.sw;
    sw_evt_c    = primed_q & (|sw_diff_c);
    del_evt_c   = primed_q & stable_c.btn_del & ~prev_q.btn_del;
    clr_evt_c   = primed_q & stable_c.btn_clr & ~prev_q.btn_clr;
    enter_evt_c = primed_q & stable_c.btn_enter & ~prev_q.btn_enter;
    act_c       = ACT_NONE;
    if (clr_evt_c)                              act_c = ACT_CLR;
    else if (enter_evt_c && !out_if.out_valid)  act_c = ACT_ENTER;
    else if (del_evt_c)                         act_c = ACT_DEL;
    else if (sw_evt_c)                          act_c = ACT_SW;
  end

  // Entry register, digit count and submit handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q           <= '0;
      primed_q         <= 1'b0;
      cur_data         <= '0;
      digit_cnt        <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= '0;
    end else begin
      prev_q   <= stable_c;
      primed_q <= primed;
      if (out_if.out_valid && out_if.out_ready) out_if.out_valid <= 1'b0;
      case (act_c)
        ACT_CLR: begin
          cur_data  <= '0;
          digit_cnt <= '0;
        end
        ACT_ENTER: begin
          out_if.out_data  <= cur_data;
          out_if.out_valid <= 1'b1;
          cur_data         <= '0;
          digit_cnt        <= '0;
        end
        ACT_DEL: begin
          cur_data <= cur_data >> 4;
          if (digit_cnt != '0) digit_cnt <= digit_cnt - DCNT_W'(1);
        end
        ACT_SW: begin
          cur_data <= {cur_data[DATA_W-5:0], lowest_set(sw_diff_c)};
          if (digit_cnt != DCNT_W'(HEX_DIGITS)) digit_cnt <= digit_cnt + DCNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
